sdram_cpu_bridge: RTL and testbench
===================================

Name: sdram_cpu_bridge

Overview:
- Initiator side of the SDRAM controller's toggle-handshake client ports: converts an 8-bit CPU byte bus into 16-bit word requests on one controller port (port1 or port2).
- Holds a single-word read cache so sequential byte reads of the same word skip the SDRAM round trip.
- Sits between the CPU/bus decoder and the SDRAM controller; one instance per controller port.

Parameters:
- CACHE_EN, 1, 1 = single-word read cache enabled; 0 = every read goes to SDRAM.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- init_n  in  1  asynchronous active-low reset.
- cpu_addr  in  24  byte address, sampled with a strobe.
- cpu_rd  in  1  single-cycle read strobe.
- cpu_wr  in  1  single-cycle write strobe.
- cpu_din  in  8  write data, sampled with cpu_wr.
- cpu_dout  out  8  read data, valid when cpu_dvalid is high and held until the next read completes.
- cpu_dvalid  out  1  one-cycle pulse when read data is delivered.
- cpu_busy  out  1  bridge cannot accept a strobe.
- flush  in  1  invalidate the cache.
- port_req  out  1  request toggle.
- port_ack  in  1  acknowledge toggle from the controller.
- port_we  out  1  1 = write.
- port_a  out  23  word address, [23:1].
- port_ds  out  2  byte enables; [1] = upper byte, [0] = lower byte.
- port_d  out  16  write data.
- port_q  in  16  read data, valid when port_ack == port_req.

Behaviour:
- Reset (init_n low): port_req=0, port_we=0, port_a=0, port_ds=2'b00, port_d=0, cpu_dout=0, cpu_dvalid=0, cpu_busy=1, cache invalid, state SYNC.
- Handshake:
  - A transaction is pending while port_req != port_ack. The bridge starts one by inverting port_req.
  - port_we, port_a, port_ds and port_d are registered in the same cycle as the toggle and stay stable until port_ack == port_req.
  - The ack can arrive any number of cycles ≥1 later.
- States: SYNC, IDLE, WAIT_RD, WAIT_WR.
- SYNC (first clock after reset release): port_req <= port_ack, because ack is not reset in the controller. Then go to IDLE with cpu_busy=0.
- IDLE, cpu_wr=1 (cpu_wr has priority; a simultaneous cpu_rd is dropped):
  - port_we=1, port_a=cpu_addr[23:1], port_d={cpu_din,cpu_din}.
  - port_ds=2'b01 when cpu_addr[0]=0, 2'b10 when cpu_addr[0]=1.
  - Toggle port_req, cpu_busy=1, go to WAIT_WR.
- IDLE, cpu_rd=1, cache hit (CACHE_EN, valid, tag == cpu_addr[23:1], and flush=0 in that cycle):
  - Next cycle: cpu_dout = selected byte (addr[0]=0 gives [7:0], 1 gives [15:8]), cpu_dvalid=1.
  - No port activity; cpu_busy stays 0.
- IDLE, cpu_rd=1, miss: port_we=0, port_ds=2'b11, port_a=cpu_addr[23:1], toggle port_req, cpu_busy=1, latch addr[0], go to WAIT_RD.
- WAIT_RD, on port_ack == port_req:
  - Cache word <= port_q, tag <= port_a, valid <= CACHE_EN.
  - cpu_dout <= selected byte, cpu_dvalid pulses for one cycle.
  - cpu_busy <= 0, go to IDLE.
  - Read latency is ack cycle + 1.
- WAIT_WR, on ack:
  - If the cache is valid and tag == port_a, merge the written byte into the cached word.
  - cpu_busy <= 0, go to IDLE. No cpu_dvalid pulse.
- cpu_busy is registered. Strobes that arrive while cpu_busy=1, including the cycle in which the ack is detected, are ignored.
- flush:
  - Clears valid the next cycle in any state.
  - If flush coincides with a WAIT_RD completion, flush wins: data is delivered, cache stays invalid.
- Reset mid-transaction: all state is abandoned. SYNC realigns port_req to port_ack, so an outstanding controller toggle is never re-issued.
- Only one transaction is outstanding at a time.

Test Plan:
- Reset release with port_ack=1 -> after 1 cycle port_req=1, cpu_busy=0; no transaction issued.
- cpu_rd at 0x001235, controller acks 6 cycles later with port_q=0xBEEF -> port_a=0x00091A, port_ds=2'b11, port_we=0; cpu_dout=0xBE with cpu_dvalid one cycle after the ack; busy high during the wait.
- Then cpu_rd at 0x001234 -> cpu_dout=0xEF, cpu_dvalid next cycle, port_req does not toggle.
- cpu_wr at 0x001234 with din=0x55 -> port_we=1, port_ds=2'b01, port_d=0x5555. After the ack, a read of 0x001234 returns 0x55 from cache with no toggle.
- Assert flush, then cpu_rd at 0x001235 -> new SDRAM request issued (cache miss).
- cpu_rd and cpu_wr together at 0x000010 -> only the write is issued; a strobe during busy and a strobe in the ack cycle are both ignored; init_n pulsed during WAIT_RD -> SYNC realignment and no spurious cpu_dvalid.

Source files
------------

// File: rtl/sdram_cpu_bridge.sv
// sdram_cpu_bridge
// Initiator side of one SDRAM controller toggle-handshake client port.
// Turns 8-bit CPU byte strobes into 16-bit word requests. It keeps a
// single-word read cache, so sequential byte reads of the same word complete
// without an SDRAM round trip.
//
// Ports:
//   clk        system clock, shared with the SDRAM controller
//   init_n     asynchronous active-low reset
//   cpu_addr   byte address, sampled with cpu_rd / cpu_wr
//   cpu_rd     single-cycle read strobe
//   cpu_wr     single-cycle write strobe (wins over a coincident cpu_rd)
//   cpu_din    write byte, sampled with cpu_wr
//   cpu_dout   read byte, held until the next read completes
//   cpu_dvalid one-cycle pulse when cpu_dout carries new read data
//   cpu_busy   strobes are ignored while high
//   flush      invalidates the cached word
//   port_req   request toggle to the controller
//   port_ack   acknowledge toggle from the controller
//   port_we    1 = write request
//   port_a     word address (cpu_addr[23:1])
//   port_ds    byte enables, [1] upper / [0] lower
//   port_d     write data (byte replicated on both lanes)
//   port_q     read data, valid once port_ack == port_req
module sdram_cpu_bridge #(
  parameter int CACHE_EN = 1
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic [23:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_dvalid,
  output logic        cpu_busy,
  input  logic        flush,
  output logic        port_req,
  input  logic        port_ack,
  output logic        port_we,
  output logic [22:0] port_a,
  output logic [1:0]  port_ds,
  output logic [15:0] port_d,
  input  logic [15:0] port_q
);

  localparam logic [1:0] S_SYNC    = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;
  localparam logic [1:0] S_WAIT_WR = 2'd3;

  localparam logic C_CACHE_EN = (CACHE_EN != 0);

  logic [1:0]  r_state;
  logic        r_port_req;
  logic        r_port_we;
  logic [22:0] r_port_a;
  logic [1:0]  r_port_ds;
  logic [15:0] r_port_d;
  logic [7:0]  r_cpu_dout;
  logic        r_cpu_dvalid;
  logic        r_cpu_busy;
  logic        r_cache_valid;
  logic [22:0] r_cache_tag;
  logic [15:0] r_cache_data;
  logic        r_rd_lsb;

  logic        w_ack_done;
  logic        w_cache_hit;
  logic        w_wr_merge;
  logic [7:0]  w_rd_byte;
  logic [7:0]  w_hit_byte;
  logic [15:0] w_merge_data;

  // The transaction is finished once the controller's toggle matches ours.
  assign w_ack_done  = (port_ack == r_port_req);
  // A flush in the strobe cycle already forces a miss.
  assign w_cache_hit = C_CACHE_EN && r_cache_valid &&
                       (r_cache_tag == cpu_addr[23:1]) && !flush;
  assign w_wr_merge  = r_cache_valid && (r_cache_tag == r_port_a);
  assign w_rd_byte   = r_rd_lsb    ? port_q[15:8]       : port_q[7:0];
  assign w_hit_byte  = cpu_addr[0] ? r_cache_data[15:8] : r_cache_data[7:0];
  assign w_merge_data = {(r_port_ds[1] ? r_port_d[15:8] : r_cache_data[15:8]),
                         (r_port_ds[0] ? r_port_d[7:0]  : r_cache_data[7:0])};

  // Bridge state machine, port request registers and read cache.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_state       <= S_SYNC;
      r_port_req    <= 1'b0;
      r_port_we     <= 1'b0;
      r_port_a      <= 23'd0;
      r_port_ds     <= 2'b00;
      r_port_d      <= 16'd0;
      r_cpu_dout    <= 8'd0;
      r_cpu_dvalid  <= 1'b0;
      r_cpu_busy    <= 1'b1;
      r_cache_valid <= 1'b0;
      r_cache_tag   <= 23'd0;
      r_cache_data  <= 16'd0;
      r_rd_lsb      <= 1'b0;
    end else begin
      r_cpu_dvalid <= 1'b0;
      case (r_state)
        S_SYNC: begin
          // The controller's ack survives our reset; adopt it so no
          // stale toggle is seen as a new request.
          r_port_req <= port_ack;
          r_cpu_busy <= 1'b0;
          r_state    <= S_IDLE;
        end
        S_IDLE: begin
          if (cpu_wr) begin
            r_port_we  <= 1'b1;
            r_port_a   <= cpu_addr[23:1];
            r_port_d   <= {cpu_din, cpu_din};
            r_port_ds  <= cpu_addr[0] ? 2'b10 : 2'b01;
            r_port_req <= ~r_port_req;
            r_cpu_busy <= 1'b1;
            r_state    <= S_WAIT_WR;
          end else if (cpu_rd) begin
            if (w_cache_hit) begin
              r_cpu_dout   <= w_hit_byte;
              r_cpu_dvalid <= 1'b1;
            end else begin
              r_port_we  <= 1'b0;
              r_port_a   <= cpu_addr[23:1];
              r_port_ds  <= 2'b11;
              r_rd_lsb   <= cpu_addr[0];
              r_port_req <= ~r_port_req;
              r_cpu_busy <= 1'b1;
              r_state    <= S_WAIT_RD;
            end
          end
        end
        S_WAIT_RD: begin
          if (w_ack_done) begin
            r_cache_data  <= port_q;
            r_cache_tag   <= r_port_a;
            r_cache_valid <= C_CACHE_EN;
            r_cpu_dout    <= w_rd_byte;
            r_cpu_dvalid  <= 1'b1;
            r_cpu_busy    <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        S_WAIT_WR: begin
          if (w_ack_done) begin
            // Keep the cached word coherent with the byte just written.
            if (w_wr_merge) begin
              r_cache_data <= w_merge_data;
            end
            r_cpu_busy <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_cpu_busy <= 1'b1;
          r_state    <= S_SYNC;
        end
      endcase
      // Placed last so it overrides a read completion in the same cycle.
      if (flush) begin
        r_cache_valid <= 1'b0;
      end
    end
  end

  assign port_req   = r_port_req;
  assign port_we    = r_port_we;
  assign port_a     = r_port_a;
  assign port_ds    = r_port_ds;
  assign port_d     = r_port_d;
  assign cpu_dout   = r_cpu_dout;
  assign cpu_dvalid = r_cpu_dvalid;
  assign cpu_busy   = r_cpu_busy;

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// Self-checking bench for sdram_cpu_bridge: table of CPU strobes with
// hand-computed expected port fields and read bytes, a behavioural
// controller that acks after a fixed delay, and a read-data scoreboard.
module tb_sdram_cpu_bridge;

  logic        clk;
  logic        init_n;
  logic [23:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_dvalid;
  logic        cpu_busy;
  logic        flush;
  logic        port_req;
  logic        port_ack;
  logic        port_we;
  logic [22:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;
  logic [15:0] port_q;

  sdram_cpu_bridge #(.CACHE_EN(1)) dut (
    .clk(clk), .init_n(init_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_dvalid(cpu_dvalid), .cpu_busy(cpu_busy), .flush(flush),
    .port_req(port_req), .port_ack(port_ack), .port_we(port_we),
    .port_a(port_a), .port_ds(port_ds), .port_d(port_d), .port_q(port_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  // Read-data scoreboard: pushed when a read strobe is driven.
  logic [7:0] sb[$];
  logic [7:0] sb_exp;

  always @(negedge clk) begin
    if (init_n && cpu_dvalid) begin
      check("dvalid_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        sb_exp = sb.pop_front();
        check("read_data", 32'(cpu_dout), 32'(sb_exp));
      end
    end
  end

  // Behavioural controller: acks ack_delay cycles after each toggle.
  logic [15:0] mem [logic [22:0]];
  logic        resp_en = 1'b0;
  logic        resp_busy = 1'b0;
  int          resp_cnt = 0;
  int          ack_delay = 6;

  always @(posedge clk) begin
    #2;
    if (resp_en) begin
      if (!resp_busy) begin
        if (port_req != port_ack) begin
          resp_busy = 1'b1;
          resp_cnt  = ack_delay;
        end
      end else begin
        resp_cnt = resp_cnt - 1;
        if (resp_cnt == 0) begin
          if (port_we) begin
            if (!mem.exists(port_a)) mem[port_a] = 16'h0000;
            if (port_ds[1]) mem[port_a][15:8] = port_d[15:8];
            if (port_ds[0]) mem[port_a][7:0]  = port_d[7:0];
          end else begin
            port_q = mem.exists(port_a) ? mem[port_a] : 16'h0000;
          end
          port_ack  = port_req;
          resp_busy = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic        flsh;
    logic        rd;
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  din;
    logic        issue;
    logic        we;
    logic [1:0]  ds;
    logic [22:0] a;
    logic [15:0] d;
    logic [7:0]  dout;
  } vec_t;

  vec_t vecs[12];

  // Drives one strobe from IDLE, checks the port request (or its absence)
  // and waits for completion.
  task automatic apply_row(input vec_t v, input string tag);
    logic req_before;
    req_before = port_req;
    cpu_addr = v.addr; cpu_din = v.din;
    cpu_rd = v.rd; cpu_wr = v.wr; flush = v.flsh;
    if (v.rd && !v.wr) sb.push_back(v.dout);
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0; flush = 1'b0;
    if (v.issue) begin
      check({tag, "_toggle"}, 32'(port_req != req_before), 32'd1);
      check({tag, "_we"}, 32'(port_we), 32'(v.we));
      check({tag, "_ds"}, 32'(port_ds), 32'(v.ds));
      check({tag, "_a"}, 32'(port_a), 32'(v.a));
      if (v.we) check({tag, "_d"}, 32'(port_d), 32'(v.d));
      check({tag, "_busy_wait"}, 32'(cpu_busy), 32'd1);
    end else begin
      check({tag, "_no_toggle"}, 32'(port_req), 32'(req_before));
      check({tag, "_busy_hit"}, 32'(cpu_busy), 32'd0);
    end
    for (int i = 0; i < 200; i++) begin
      if (!cpu_busy) break;
      @(negedge clk);
    end
    check({tag, "_busy_release"}, 32'(cpu_busy), 32'd0);
    @(negedge clk);
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic req1;
  vec_t hv;

  initial begin
    mem[23'h00091A] = 16'hBEEF;
    mem[23'h000008] = 16'h9876;
    mem[23'h000080] = 16'h4321;
    mem[23'h000200] = 16'hCAFE;

    //            flsh  rd    wr    addr         din    issue we    ds     a             d        dout
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 24'h001235, 8'h00, 1'b1, 1'b0, 2'b11, 23'h00091A, 16'h0000, 8'hBE};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 24'h001234, 8'h00, 1'b0, 1'b0, 2'b00, 23'h000000, 16'h0000, 8'hEF};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 24'h001234, 8'h55, 1'b1, 1'b1, 2'b01, 23'h00091A, 16'h5555, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 24'h001234, 8'h00, 1'b0, 1'b0, 2'b00, 23'h000000, 16'h0000, 8'h55};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 24'h001235, 8'h00, 1'b0, 1'b0, 2'b00, 23'h000000, 16'h0000, 8'hBE};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 24'h001235, 8'h00, 1'b1, 1'b0, 2'b11, 23'h00091A, 16'h0000, 8'hBE};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 24'h001235, 8'hA5, 1'b1, 1'b1, 2'b10, 23'h00091A, 16'hA5A5, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 24'h001235, 8'h00, 1'b0, 1'b0, 2'b00, 23'h000000, 16'h0000, 8'hA5};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 24'h000010, 8'h3C, 1'b1, 1'b1, 2'b01, 23'h000008, 16'h3C3C, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 24'h000011, 8'h00, 1'b1, 1'b0, 2'b11, 23'h000008, 16'h0000, 8'h98};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 24'h000010, 8'h00, 1'b0, 1'b0, 2'b00, 23'h000000, 16'h0000, 8'h3C};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 24'h001234, 8'h00, 1'b1, 1'b0, 2'b11, 23'h00091A, 16'h0000, 8'h55};

    init_n = 1'b0; port_ack = 1'b1; port_q = 16'h0000;
    cpu_addr = 24'd0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_din = 8'd0; flush = 1'b0;

    // Reset state, then SYNC with a controller ack left at 1.
    repeat (3) @(negedge clk);
    check("rst_req", 32'(port_req), 32'd0);
    check("rst_we", 32'(port_we), 32'd0);
    check("rst_a", 32'(port_a), 32'd0);
    check("rst_ds", 32'(port_ds), 32'd0);
    check("rst_d", 32'(port_d), 32'd0);
    check("rst_dout", 32'(cpu_dout), 32'd0);
    check("rst_dvalid", 32'(cpu_dvalid), 32'd0);
    check("rst_busy", 32'(cpu_busy), 32'd1);
    init_n = 1'b1;
    @(negedge clk);
    check("sync_req", 32'(port_req), 32'd1);
    check("sync_busy", 32'(cpu_busy), 32'd0);
    repeat (4) @(negedge clk);
    check("sync_no_tx", 32'(port_req), 32'(port_ack));
    resp_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply_row(vecs[i], $sformatf("row%0d", i));
    end

    // Strobe while busy, strobe plus flush in the ack cycle.
    req1 = port_req;
    cpu_addr = 24'h000100; cpu_rd = 1'b1;
    sb.push_back(8'h21);
    @(negedge clk);
    cpu_rd = 1'b0;
    check("b_toggle", 32'(port_req != req1), 32'd1);
    req1 = port_req;
    cpu_addr = 24'h000200; cpu_wr = 1'b1; cpu_din = 8'h11;
    @(negedge clk);
    cpu_wr = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (port_ack == port_req) break;
      @(negedge clk);
    end
    check("b_ack_seen", 32'(port_ack == port_req), 32'd1);
    check("b_ack_cycle_busy", 32'(cpu_busy), 32'd1);
    check("b_ack_cycle_dvalid", 32'(cpu_dvalid), 32'd0);
    cpu_addr = 24'h000300; cpu_wr = 1'b1; cpu_din = 8'h77; flush = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0; flush = 1'b0;
    check("b_dvalid_after_ack", 32'(cpu_dvalid), 32'd1);
    check("b_busy_after_ack", 32'(cpu_busy), 32'd0);
    repeat (8) @(negedge clk);
    check("b_ignored_req", 32'(port_req), 32'(req1));
    check("b_ignored_a", 32'(port_a), 32'h000080);
    check("b_ignored_we", 32'(port_we), 32'd0);
    // Flush coincided with completion: the word must not be cached.
    hv = '{1'b0, 1'b1, 1'b0, 24'h000101, 8'h00, 1'b1, 1'b0, 2'b11, 23'h000080, 16'h0000, 8'h43};
    apply_row(hv, "flush_wins");

    // Reset during WAIT_RD while the controller completes the toggle.
    cpu_addr = 24'h000400; cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
    check("c_busy", 32'(cpu_busy), 32'd1);
    resp_en = 1'b0; resp_busy = 1'b0;
    port_ack = port_req;
    init_n = 1'b0;
    @(negedge clk);
    check("c_rst_req", 32'(port_req), 32'd0);
    check("c_rst_busy", 32'(cpu_busy), 32'd1);
    init_n = 1'b1;
    @(negedge clk);
    check("c_realign", 32'(port_req), 32'(port_ack));
    check("c_busy_sync", 32'(cpu_busy), 32'd0);
    repeat (10) @(negedge clk);
    check("c_no_reissue", 32'(port_req), 32'(port_ack));
    check("c_no_dvalid_sb", 32'(sb.size()), 32'd0);
    resp_en = 1'b1;
    hv = '{1'b0, 1'b1, 1'b0, 24'h000401, 8'h00, 1'b1, 1'b0, 2'b11, 23'h000200, 16'h0000, 8'hCA};
    apply_row(hv, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
